// File: rtl/clock_text_writer.sv
// clock_text_writer
//   Renders packed-BCD minutes/seconds as the five ASCII characters "MM:SS"
//   into the text-mode character RAM through a ready-qualified write port.
//   A sequence starts only when the displayed time has changed. All five
//   characters of a sequence come from one snapshot of {min,sec}.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   min       packed BCD minutes ([7:4] tens, [3:0] ones)
//   sec       packed BCD seconds ([7:4] tens, [3:0] ones)
//   wr_ready  RAM port accepts a write this cycle
//   wr_en     write request, held until accepted
//   wr_addr   character address (ROW*COLS + COL + index)
//   wr_data   ASCII character
//   busy      a write sequence is in progress
module clock_text_writer #(
   parameter int COLS   = 80,
   parameter int ROW    = 0,
   parameter int COL    = 75,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        min,
   input  logic [7:0]        sec,
   input  logic              wr_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy
);

   localparam int                BASE_I = ROW * COLS + COL;
   localparam logic [ADDR_W-1:0] BASE   = BASE_I[ADDR_W-1:0];

   typedef enum logic {IDLE, WRITE} state_t;

   state_t      state;
   logic [2:0]  idx;
   logic [15:0] snap;
   logic [15:0] prev;
   logic        dirty;
   logic [15:0] cur;
   logic        change;
   logic        capture;
   logic [2:0]  idx_nxt;

   // BCD nibble to ASCII digit; non-decimal nibbles show as '?'
   function automatic logic [7:0] digit(input logic [3:0] n);
      if (n <= 4'd9)
         return 8'h30 + {4'h0, n};
      else
         return 8'h3F;
   endfunction

   // Character at position i of "MM:SS" for time value t = {min,sec}
   function automatic logic [7:0] char_of(input logic [15:0] t, input logic [2:0] i);
      case (i)
         3'd0:    return digit(t[15:12]);
         3'd1:    return digit(t[11:8]);
         3'd2:    return 8'h3A;
         3'd3:    return digit(t[7:4]);
         default: return digit(t[3:0]);
      endcase
   endfunction

   assign cur     = {min, sec};
   assign change  = (cur != prev);
   assign capture = (state == IDLE) && dirty;
   assign idx_nxt = idx + 3'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= 3'd0;
         snap    <= 16'h0000;
         prev    <= 16'h0000;
         dirty   <= 1'b1;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= 8'h00;
         busy    <= 1'b0;
      end else begin
         prev <= cur;

         // A capture samples the current inputs, so a change arriving in the
         // capture cycle is already reflected in the new snapshot.
         if (capture)
            dirty <= 1'b0;
         else if (change)
            dirty <= 1'b1;

         case (state)
            IDLE: begin
               if (dirty) begin
                  snap    <= cur;
                  idx     <= 3'd0;
                  state   <= WRITE;
                  busy    <= 1'b1;
                  wr_en   <= 1'b1;
                  wr_addr <= BASE;
                  wr_data <= char_of(cur, 3'd0);
               end
            end
            WRITE: begin
               // wr_en is always high in WRITE; without ready everything holds
               if (wr_ready) begin
                  if (idx == 3'd4) begin
                     wr_en <= 1'b0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     idx     <= idx_nxt;
                     wr_addr <= BASE + ADDR_W'(idx_nxt);
                     wr_data <= char_of(snap, idx_nxt);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               wr_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_text_writer.sv
// tb_clock_text_writer
//   Directed bench for clock_text_writer: reset state, initial rewrite,
//   time update latency, backpressure, change during a sequence, invalid
//   BCD digits and reset in the middle of a sequence.
module tb_clock_text_writer;

   localparam int ADDR_W = 12;

   logic              clk;
   logic              reset;
   logic [7:0]        min;
   logic [7:0]        sec;
   logic              wr_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;

   int n_cmp;
   int n_err;

   clock_text_writer #(
      .COLS   (80),
      .ROW    (0),
      .COL    (75),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .min      (min),
      .sec      (sec),
      .wr_ready (wr_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge; observe on the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input int i, input logic [7:0] d);
      chk({tag, "_en"},   32'(wr_en), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_addr"}, 32'(wr_addr), 32'(75 + i));
      chk({tag, "_data"}, 32'(wr_data), 32'(d));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_en"},   32'(wr_en), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Five back-to-back accepted beats, then idle
   task automatic chk_seq(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3, input logic [7:0] d4);
      chk_beat({tag, "_b0"}, 0, d0); tick();
      chk_beat({tag, "_b1"}, 1, d1); tick();
      chk_beat({tag, "_b2"}, 2, d2); tick();
      chk_beat({tag, "_b3"}, 3, d3); tick();
      chk_beat({tag, "_b4"}, 4, d4); tick();
      chk_idle({tag, "_end"});
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      reset    = 1'b1;
      min      = 8'h00;
      sec      = 8'h00;
      wr_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_en",   32'(wr_en), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
      chk("rst_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Forced rewrite of 00:00 right after reset release
      reset = 1'b0;
      tick();
      chk_seq("init", 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30);
      tick(); chk_idle("init_q1");
      tick(); chk_idle("init_q2");
      tick(); chk_idle("init_q3");

      // 12:59: change sets dirty on first edge, writes start on the second
      min = 8'h12;
      sec = 8'h59;
      tick(); chk_idle("upd_lat");
      tick();
      chk_seq("upd", 8'h31, 8'h32, 8'h3A, 8'h35, 8'h39);
      tick(); chk_idle("upd_q1");
      tick(); chk_idle("upd_q2");

      // 34:21 with wr_ready low for three cycles while beat 2 is presented
      min = 8'h34;
      sec = 8'h21;
      tick();
      tick();
      chk_beat("bp_b0", 0, 8'h33); tick();
      chk_beat("bp_b1", 1, 8'h34); tick();
      chk_beat("bp_b2", 2, 8'h3A);
      wr_ready = 1'b0;
      tick(); chk_beat("bp_hold1", 2, 8'h3A);
      tick(); chk_beat("bp_hold2", 2, 8'h3A);
      tick(); chk_beat("bp_hold3", 2, 8'h3A);
      wr_ready = 1'b1;
      tick();
      chk_beat("bp_b3", 3, 8'h32); tick();
      chk_beat("bp_b4", 4, 8'h31); tick();
      chk_idle("bp_end");
      tick(); chk_idle("bp_q1");

      // 00:07, seconds move to 08 while beat 1 is on the port
      min = 8'h00;
      sec = 8'h07;
      tick();
      tick();
      chk_beat("chg_b0", 0, 8'h30); tick();
      sec = 8'h08;
      chk_beat("chg_b1", 1, 8'h30); tick();
      chk_beat("chg_b2", 2, 8'h3A); tick();
      chk_beat("chg_b3", 3, 8'h30); tick();
      chk_beat("chg_b4", 4, 8'h37); tick();
      chk_idle("chg_gap");
      tick();
      chk_seq("chg2", 8'h30, 8'h30, 8'h3A, 8'h30, 8'h38);
      tick(); chk_idle("chg2_q1");

      // Non-decimal nibbles render as '?'
      min = 8'h1A;
      sec = 8'hF3;
      tick();
      tick();
      chk_seq("bad", 8'h31, 8'h3F, 8'h3A, 8'h3F, 8'h33);
      tick(); chk_idle("bad_q1");

      // Reset while beat 3 is presented, then full rewrite of 45:16
      min = 8'h45;
      sec = 8'h16;
      tick();
      tick();
      chk_beat("rmid_b0", 0, 8'h34); tick();
      chk_beat("rmid_b1", 1, 8'h35); tick();
      chk_beat("rmid_b2", 2, 8'h3A); tick();
      chk_beat("rmid_b3", 3, 8'h31);
      reset = 1'b1;
      tick();
      chk("rmid_rst_en",   32'(wr_en), 32'd0);
      chk("rmid_rst_busy", 32'(busy), 32'd0);
      chk("rmid_rst_addr", 32'(wr_addr), 32'd0);
      reset = 1'b0;
      tick();
      chk_seq("rmid_re", 8'h34, 8'h35, 8'h3A, 8'h31, 8'h36);
      tick(); chk_idle("rmid_q1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
